// File: rtl/mem_arbiter.sv
// Shares one word-addressed memory port between instruction fetch (I) and load/store (D), one read in flight.
// Define MEM_ARB_STARVE_EN to let a fetch denied STARVE_LIMIT cycles in a row win the next arbitration.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [29:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_re,
  input  logic [3:0]  d_we,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic [3:0]  m_we,
  output logic [29:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  typedef enum logic {IDLE, WAIT_R} state_t;

  state_t state, state_next;
  logic   owner_d, owner_d_next;
  logic   d_req, d_store, starve_hit;
  logic   pick_i, pick_d, grant, read_grant;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be within 1..15");
  end

  // A nonzero byte-enable makes it a store regardless of d_re.
  assign d_store = |d_we;
  assign d_req   = d_re | d_store;

`ifdef MEM_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      starve_cnt <= '0;
    else if (i_gnt)
      starve_cnt <= '0;
    else if (state == IDLE && i_req && starve_cnt != LIMIT)
      starve_cnt <= starve_cnt + 4'd1;
  end

  assign starve_hit = (starve_cnt == LIMIT);
`else
  assign starve_hit = 1'b0;
`endif

  assign pick_i     = (state == IDLE) && i_req && (!d_req || starve_hit);
  assign pick_d     = (state == IDLE) && d_req && !pick_i;
  assign grant      = (pick_i | pick_d) & m_gnt;
  assign read_grant = grant & (pick_i | !d_store);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      owner_d <= 1'b1;
    end else begin
      state   <= state_next;
      owner_d <= owner_d_next;
    end
  end

  always_comb begin
    state_next   = state;
    owner_d_next = owner_d;
    case (state)
      IDLE: begin
        if (read_grant) begin
          state_next   = WAIT_R;
          owner_d_next = pick_d;
        end
      end
      WAIT_R: begin
        if (m_rvalid)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read data is broadcast to both sides; only the valid strobes are steered to the owner.
  always_comb begin
    m_req    = (state == IDLE) && (i_req || d_req);
    m_we     = pick_d ? d_we : 4'b0000;
    m_addr   = pick_d ? d_addr : i_addr;
    m_wdata  = pick_d ? d_wdata : 32'h0;
    i_gnt    = pick_i & m_gnt;
    d_gnt    = pick_d & m_gnt;
    i_rvalid = (state == WAIT_R) && m_rvalid && !owner_d;
    d_rvalid = (state == WAIT_R) && m_rvalid && owner_d;
  end

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single word-addressed memory port between the instruction-fetch requester (I) and the load/store requester (D).
- Sits between the core's fetch unit and mem stage on one side and the memory/bus on the other.
- Allows one outstanding read at a time.
- Data side has fixed priority, with an optional starvation guard for fetch.

Parameters:
STARVE_LIMIT, 4, consecutive cycles a pending fetch may be denied before it wins the next grant (used only with MEM_ARB_STARVE_EN; legal range 1..15).

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
i_req  input  1  fetch read request; held stable until i_gnt
i_addr  input  30  fetch word address
i_gnt  output  1  fetch request accepted this cycle
i_rvalid  output  1  fetch read data valid
i_rdata  output  32  fetch read data
d_re  input  1  load request
d_we  input  4  store byte enables; nonzero = store request
d_addr  input  30  data word address
d_wdata  input  32  store data, already lane-aligned
d_gnt  output  1  data request accepted this cycle
d_rvalid  output  1  load data valid
d_rdata  output  32  load data
m_req  output  1  request to memory
m_we  output  4  byte enables to memory; 0 = read
m_addr  output  30  word address to memory
m_wdata  output  32  write data to memory
m_gnt  input  1  memory accepts m_req this cycle
m_rvalid  input  1  memory read data valid
m_rdata  input  32  memory read data

Behaviour:
- States: IDLE, WAIT_R. Internal owner register: I or D.
- Reset: async on resetn low. State=IDLE, owner=D, starvation counter=0.
- All outputs are combinational, so with no requests they read 0: i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we all 0.
- D request = d_re OR (d_we != 0). If d_we != 0 the request is a store and d_re is ignored; it is a read only when d_we = 0 and d_re = 1.
- IDLE arbitration (combinational):
  - D wins if D requests; otherwise I wins if i_req.
  - m_req = any request. m_addr, m_we and m_wdata are taken from the winner; for I, m_we=0 and m_wdata=0.
  - x_gnt = winner AND m_gnt. The loser's gnt stays 0.
- Transitions:
  - Accepted store: no response, stays IDLE, next request may issue the following cycle.
  - Accepted read (I, or D with d_we=0): owner <= winner, next state WAIT_R.
- WAIT_R:
  - m_req=0, both gnts 0.
  - On m_rvalid: owner's x_rvalid=1 in the same cycle, then back to IDLE. A new request can issue the next cycle.
  - Read latency is set by memory, minimum 1 cycle after acceptance.
- i_rdata and d_rdata both carry m_rdata at all times; only the rvalid strobes are steered.
- Boundary conditions:
  - m_rvalid in IDLE is ignored: no rvalid to either side.
  - Requests asserted during WAIT_R are held off until the state returns to IDLE.
  - If m_gnt is low, the request stays presented and the winner may change the next cycle. A newly arriving D overrides a pending I, because no grant has been issued.
  - resetn asserted in WAIT_R drops the outstanding read; a late m_rvalid is then ignored.
- Protocol contract: requesters keep address/data stable while req is asserted and not granted. Memory never asserts m_rvalid for writes.

Optional Feature:
- Macro MEM_ARB_STARVE_EN.
- When defined, a 4-bit counter:
  - increments each cycle i_req is pending in IDLE and not granted;
  - saturates at STARVE_LIMIT;
  - clears on i_gnt.
- While the counter = STARVE_LIMIT, I wins arbitration over D.
- When undefined: no counter is built and D always has priority.

Test Plan:
- Reset: resetn=0 mid-WAIT_R, then release; inject m_rvalid=1 -> i_rvalid=d_rvalid=0, m_req=0, state IDLE.
- Simultaneous requests: i_req=1 addr 0x10 and d_re=1 addr 0x20, m_gnt=1 -> d_gnt=1, i_gnt=0, m_addr=0x20. Return m_rvalid two cycles later with m_rdata=0xDEADBEEF -> d_rvalid=1, d_rdata=0xDEADBEEF. The next cycle -> i_gnt=1, m_addr=0x10.
- Store: d_we=4'b0100, d_wdata=0x00AB0000, m_gnt=1 -> m_we=4'b0100, d_gnt=1, no rvalid, state stays IDLE. A following i_req is granted the next cycle.
- Backpressure: i_req held with m_gnt=0 for 3 cycles -> m_req=1, i_gnt=0 throughout. Raise d_re in cycle 2 -> m_addr switches to d_addr. m_gnt=1 -> d_gnt only.
- Hold-off: assert d_re in WAIT_R -> no m_req until m_rvalid for the I read. d_gnt is granted the cycle after.
- With MEM_ARB_STARVE_EN, STARVE_LIMIT=4: D requests every cycle and i_req is held -> i_gnt=1 on the 5th arbitration cycle; the counter then returns to 0.
